// File: rtl/alu_pkg.sv
// ALU package: default widths, function-code constants and shifter mode type.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT      = 32;
  localparam int unsigned ALU_FUNC_WIDTH_DEFAULT = 5;

  // Function codes; only the low five bits of f are ever decoded against these.
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOT   = 5'd5;
  localparam logic [4:0] ALU_SHL   = 5'd6;
  localparam logic [4:0] ALU_SHR   = 5'd7;
  localparam logic [4:0] ALU_SAR   = 5'd8;
  localparam logic [4:0] ALU_ROL   = 5'd9;
  localparam logic [4:0] ALU_ROR   = 5'd10;
  localparam logic [4:0] ALU_MIN   = 5'd11;
  localparam logic [4:0] ALU_MAX   = 5'd12;
  localparam logic [4:0] ALU_ZERO  = 5'd13;
  localparam logic [4:0] ALU_ONE   = 5'd14;
  localparam logic [4:0] ALU_INC   = 5'd15;
  localparam logic [4:0] ALU_DEC   = 5'd16;
  localparam logic [4:0] ALU_NEG   = 5'd17;
  localparam logic [4:0] ALU_PASSA = 5'd18;
  localparam logic [4:0] ALU_PASSB = 5'd19;
  localparam logic [4:0] ALU_NOP   = 5'd20;

  // Shifter modes, in the same order as codes ALU_SHL..ALU_ROR.
  typedef enum logic [2:0] {
    SH_SHL = 3'd0,
    SH_SHR = 3'd1,
    SH_SAR = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter/rotator for the ALU shift codes.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned ALU_WIDTH = ALU_WIDTH_DEFAULT,
  localparam int unsigned SHW = $clog2(ALU_WIDTH)
) (
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [SHW-1:0]       amount,
  input  shift_mode_e          mode,
  output logic [ALU_WIDTH-1:0] result
);

  // Rotates come from shifting a doubled copy of a, so amount 0 is naturally a no-op.
  logic [2*ALU_WIDTH-1:0] rol_wide;
  logic [2*ALU_WIDTH-1:0] ror_wide;

  assign rol_wide = {a, a} << amount;
  assign ror_wide = {a, a} >> amount;

  // Select the shift flavour; unused mode encodings give 0.
  always_comb begin
    result = '0;
    case (mode)
      SH_SHL:  result = a << amount;
      SH_SHR:  result = a >> amount;
      SH_SAR:  result = ALU_WIDTH'($signed(a) >>> amount);
      SH_ROL:  result = rol_wide[2*ALU_WIDTH-1:ALU_WIDTH];
      SH_ROR:  result = ror_wide[ALU_WIDTH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: combinational function decoder feeding one output register.
// Optional macro ALU_SHIFT_EN enables codes 6-10 via alu_shifter; without it
// those codes behave as reserved (s = 0, co = 0) and no shifter is built.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned ALU_WIDTH      = ALU_WIDTH_DEFAULT,
  parameter int unsigned ALU_FUNC_WIDTH = ALU_FUNC_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ALU_WIDTH-1:0]      a,
  input  logic [ALU_WIDTH-1:0]      b,
  input  logic                      ci,
  input  logic [ALU_FUNC_WIDTH-1:0] f,
  output logic [ALU_WIDTH-1:0]      s,
  output logic                      co
);

  logic [ALU_WIDTH-1:0] s_q, s_d;
  logic                 co_q, co_d;

  // Any set bit above the five decoded bits makes the code reserved.
  logic f_hi;
  generate
    if (ALU_FUNC_WIDTH > 5) begin : g_fhi
      assign f_hi = |f[ALU_FUNC_WIDTH-1:5];
    end else begin : g_nofhi
      assign f_hi = 1'b0;
    end
  endgenerate

  // Extended-width arithmetic: the extra top bit is the carry or borrow.
  logic [ALU_WIDTH:0] add_w, sub_w, inc_w, dec_w;
  assign add_w = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, ci};
  assign sub_w = {1'b0, a} - {1'b0, b} - {{ALU_WIDTH{1'b0}}, ci};
  assign inc_w = {1'b0, a} + (ALU_WIDTH+1)'(1);
  assign dec_w = {1'b0, a} - (ALU_WIDTH+1)'(1);

`ifdef ALU_SHIFT_EN
  logic [ALU_WIDTH-1:0] shift_res;
  logic [4:0]           shift_sel;
  assign shift_sel = f[4:0] - ALU_SHL;

  alu_shifter #(
    .ALU_WIDTH (ALU_WIDTH)
  ) u_shifter (
    .a      (a),
    .amount (b[$clog2(ALU_WIDTH)-1:0]),
    .mode   (shift_mode_e'(shift_sel[2:0])),
    .result (shift_res)
  );
`endif

  // Function decoder: default is the reserved result (0, 0); NOP recirculates.
  always_comb begin
    s_d  = '0;
    co_d = 1'b0;
    if (!f_hi) begin
      case (f[4:0])
        ALU_ADD:   begin s_d = add_w[ALU_WIDTH-1:0]; co_d = add_w[ALU_WIDTH]; end
        ALU_SUB:   begin s_d = sub_w[ALU_WIDTH-1:0]; co_d = sub_w[ALU_WIDTH]; end
        ALU_AND:   s_d = a & b;
        ALU_OR:    s_d = a | b;
        ALU_XOR:   s_d = a ^ b;
        ALU_NOT:   s_d = ~a;
`ifdef ALU_SHIFT_EN
        ALU_SHL, ALU_SHR, ALU_SAR, ALU_ROL, ALU_ROR: s_d = shift_res;
`endif
        ALU_MIN:   s_d = (b < a) ? b : a;
        ALU_MAX:   s_d = (b > a) ? b : a;
        ALU_ZERO:  s_d = '0;
        ALU_ONE:   s_d = ALU_WIDTH'(1);
        ALU_INC:   begin s_d = inc_w[ALU_WIDTH-1:0]; co_d = inc_w[ALU_WIDTH]; end
        ALU_DEC:   begin s_d = dec_w[ALU_WIDTH-1:0]; co_d = dec_w[ALU_WIDTH]; end
        ALU_NEG:   s_d = '0 - a;
        ALU_PASSA: s_d = a;
        ALU_PASSB: s_d = b;
        ALU_NOP:   begin s_d = s_q; co_d = co_q; end
        default:   begin s_d = '0; co_d = 1'b0; end
      endcase
    end
  end

  // Output register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (default 32-bit, 5-bit function select).
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;
  logic [4:0]  f;
  logic [31:0] s;
  logic        co;

  int checks;
  int errors;

  alu #(
    .ALU_WIDTH      (32),
    .ALU_FUNC_WIDTH (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .f   (f),
    .s   (s),
    .co  (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply an operation away from the edge, then sample just after the edge.
  task automatic op(input logic [4:0] fn, input logic [31:0] av, input logic [31:0] bv,
                    input logic civ);
    @(negedge clk);
    f  = fn;
    a  = av;
    b  = bv;
    ci = civ;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_op(input string tag, input logic [4:0] fn, input logic [31:0] av,
                        input logic [31:0] bv, input logic civ,
                        input logic [31:0] exp_s, input logic exp_co);
    op(fn, av, bv, civ);
    chk({tag, ".s"}, s, exp_s);
    chk({tag, ".co"}, {31'd0, co}, {31'd0, exp_co});
    $display("op %s f=%0d a=%h b=%h ci=%0b -> s=%h co=%0b", tag, fn, av, bv, civ, s, co);
  endtask

  // Overall time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  logic [31:0] sh_sar, sh_rol, sh_shl0, sh_shr, sh_ror;

  initial begin
    checks = 0;
    errors = 0;
`ifdef ALU_SHIFT_EN
    sh_sar = 32'hF800_0000; sh_rol = 32'h0000_0001; sh_shl0 = 32'h0000_0001;
    sh_shr = 32'h0000_0001; sh_ror = 32'h8000_0000;
`else
    sh_sar = 32'h0; sh_rol = 32'h0; sh_shl0 = 32'h0; sh_shr = 32'h0; sh_ror = 32'h0;
`endif

    // Reset with NOP applied, then release and hold for three cycles.
    rst = 1'b1; f = ALU_NOP; a = 32'h1234_5678; b = 32'h9ABC_DEF0; ci = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.s", s, 32'h0);
    chk("reset.co", {31'd0, co}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("nop_after_reset.s", s, 32'h0);
      chk("nop_after_reset.co", {31'd0, co}, 32'h0);
    end

    // Arithmetic.
    chk_op("add_1_2",     ALU_ADD, 32'd1,        32'd2,        1'b0, 32'd3,        1'b0);
    chk_op("add_wrap",    ALU_ADD, 32'hFFFF_FFFF, 32'd1,       1'b0, 32'h0,        1'b1);
    chk_op("add_ci",      ALU_ADD, 32'd5,        32'd6,        1'b1, 32'd12,       1'b0);
    chk_op("max_eq",      ALU_MAX, 32'd2,        32'd2,        1'b0, 32'd2,        1'b0);
    chk_op("min_5_9",     ALU_MIN, 32'd5,        32'd9,        1'b0, 32'd5,        1'b0);
    chk_op("max_5_9",     ALU_MAX, 32'd5,        32'd9,        1'b0, 32'd9,        1'b0);
    chk_op("sub_borrow",  ALU_SUB, 32'd0,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b1);
    chk_op("sub_10_3",    ALU_SUB, 32'd10,       32'd3,        1'b0, 32'd7,        1'b0);

    // Logic.
    chk_op("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h00F0_1234, 1'b0);
    chk_op("or",  ALU_OR,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'hFFF0_FFFF, 1'b0);
    chk_op("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'hFF00_EDCB, 1'b0);
    chk_op("not", ALU_NOT, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h0F0F_EDCB, 1'b0);

    // Constants and reserved codes, each preceded by a carry-producing op.
    chk_op("pre_carry",   ALU_ADD,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1);
    chk_op("one",         ALU_ONE,  32'd2, 32'd0, 1'b1, 32'd1, 1'b0);
    chk_op("pre_carry2",  ALU_ADD,  32'hFFFF_FFFF, 32'd3, 1'b0, 32'd2, 1'b1);
    chk_op("reserved21",  5'd21,    32'd7, 32'd9, 1'b1, 32'h0, 1'b0);
    chk_op("zero",        ALU_ZERO, 32'd7, 32'd9, 1'b1, 32'h0, 1'b0);
    chk_op("pass_b",      ALU_PASSB, 32'd7, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
    chk_op("reserved31",  5'd31,    32'd7, 32'd9, 1'b1, 32'h0, 1'b0);

    // Unary arithmetic.
    chk_op("inc_wrap", ALU_INC,   32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0,         1'b1);
    chk_op("inc_7",    ALU_INC,   32'd7,         32'd0, 1'b1, 32'd8,         1'b0);
    chk_op("dec_0",    ALU_DEC,   32'd0,         32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    chk_op("dec_5",    ALU_DEC,   32'd5,         32'd0, 1'b1, 32'd4,         1'b0);
    chk_op("neg_1",    ALU_NEG,   32'd1,         32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    chk_op("pass_a",   ALU_PASSA, 32'hDEAD_BEEF, 32'd1, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Shifts (zero when the shifter is not built).
    chk_op("sar_4",  ALU_SAR, 32'h8000_0000, 32'd4,  1'b0, sh_sar,  1'b0);
    chk_op("rol_1",  ALU_ROL, 32'h8000_0000, 32'd1,  1'b0, sh_rol,  1'b0);
    chk_op("shl_0",  ALU_SHL, 32'h0000_0001, 32'h20, 1'b0, sh_shl0, 1'b0);
    chk_op("shr_31", ALU_SHR, 32'h8000_0000, 32'd31, 1'b0, sh_shr,  1'b0);
    chk_op("ror_1",  ALU_ROR, 32'h0000_0001, 32'd1,  1'b0, sh_ror,  1'b0);

    // NOP holds result and carry, asynchronous reset clears them mid-cycle.
    chk_op("hold_src", ALU_ADD, 32'hFFFF_FFFF, 32'd4, 1'b0, 32'd3, 1'b1);
    chk_op("nop1",     ALU_NOP, 32'd100, 32'd200, 1'b1, 32'd3, 1'b1);
    chk_op("nop2",     ALU_NOP, 32'd100, 32'd200, 1'b1, 32'd3, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.s", s, 32'h0);
    chk("async_rst.co", {31'd0, co}, 32'h0);
    $display("op async_rst -> s=%h co=%0b", s, co);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("nop_after_rst.s", s, 32'h0);
    chk("nop_after_rst.co", {31'd0, co}, 32'h0);

    // First edge after a fresh release registers the op then present.
    @(negedge clk);
    rst = 1'b1;
    f = ALU_PASSB; a = 32'd0; b = 32'h0000_0055; ci = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge.s", s, 32'h0000_0055);
    chk("first_edge.co", {31'd0, co}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter ALU_WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter ALU_FUNC_WIDTH, default 5, function-select width in bits; SHALL be >= 5.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a  input  ALU_WIDTH  operand A.
REQ-006 b  input  ALU_WIDTH  operand B.
REQ-007 ci  input  1  carry/borrow in.
REQ-008 f  input  ALU_FUNC_WIDTH  function select.
REQ-009 s  output  ALU_WIDTH  registered result.
REQ-010 co  output  1  registered carry/borrow out.

Function
REQ-011 s and co SHALL be registered, with latency exactly one clk cycle from inputs sampled at a rising edge; a new operation is accepted every cycle and there is no handshake.
REQ-012 Arithmetic is unsigned modulo 2^ALU_WIDTH; co = 0 for every function not listed as producing a carry.
REQ-013 Function codes (decimal), with result s:
- 0 ADD: a+b+ci; co = carry out of bit ALU_WIDTH-1.
- 1 SUB: a-b-ci; co = 1 on borrow.
- 2 AND; 3 OR; 4 XOR; 5 NOT: ~a.
- 6 SHL, 7 SHR (logical), 8 SAR, 9 ROL, 10 ROR: a shifted/rotated by b[log2(ALU_WIDTH)-1:0].
- 11 MIN, 12 MAX: unsigned minimum/maximum of a, b; equal operands give a.
- 13 ZERO: 0.
- 14 ONE: 1, independent of a, b, ci.
- 15 INC: a+1, co = carry.
- 16 DEC: a-1, co = borrow.
- 17 NEG: 0-a.
- 18 PASSA: a.
- 19 PASSB: b.
- 20 NOP: s and co hold their previous values.
REQ-014 Codes 21 to 2^ALU_FUNC_WIDTH-1 are reserved: s = 0, co = 0.
REQ-015 Shift amount 0 SHALL return a unchanged; SAR SHALL replicate a[ALU_WIDTH-1].
REQ-016 Inputs containing X/Z are not required to produce defined outputs.

Reset
REQ-017 While rst = 1, s = 0 and co = 0 immediately, independent of clk.
REQ-018 The first rising edge after rst deasserts SHALL register the operation then present on the inputs.
REQ-019 Assertion of rst during a NOP sequence SHALL clear the held values; subsequent NOPs hold 0.

Configuration
REQ-020 Macro ALU_SHIFT_EN: when defined, codes 6-10 SHALL function per REQ-013.
REQ-021 When ALU_SHIFT_EN is not defined, no shifter SHALL be instantiated and codes 6-10 SHALL behave as reserved (s = 0, co = 0).

Structure
REQ-022 Package alu_pkg SHALL hold the ALU_WIDTH/ALU_FUNC_WIDTH defaults and named constants ALU_ADD through ALU_NOP for all codes in REQ-013.
REQ-023 One sub-module, alu_shifter (combinational; a, amount, mode in; result out), SHALL implement codes 6-10 and be instantiated only under ALU_SHIFT_EN.
REQ-024 The top module SHALL contain a combinational function decoder feeding a single output register stage.

Verification
REQ-025 rst=1, then release with f=20 (NOP): s = 0, co = 0, and they remain 0 over 3 cycles.
REQ-026 a=1, b=2, ci=0, f=ADD -> next cycle s=3, co=0; a=0xFFFFFFFF, b=1, ci=0 -> s=0, co=1.
REQ-027 a=2, b=2, f=MAX -> s=2; a=5, b=9, f=MIN -> s=5; a=0, b=0, f=SUB, ci=1 -> s=0xFFFFFFFF, co=1.
REQ-028 a=2, b=0, f=ONE -> s=1, co=0; f=21 -> s=0, co=0.
REQ-029 With ALU_SHIFT_EN: a=0x80000000, b=4, f=SAR -> s=0xF8000000; b=1, f=ROL -> s=1. Without ALU_SHIFT_EN the same stimulus gives s=0.
REQ-030 ADD 1+2 registered, then f=NOP for 2 cycles -> s holds 3; rst asserted mid-cycle -> s=0 before the next clk edge.
